// File: rtl/data_selector_pkg.sv
// Shared definitions for the sequenced data selector: FSM encodings,
// program-entry field layout, width derivation and lane parity helper.
package data_selector_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef logic [1:0] state_t;

  // Entry layout, LSB first: {regs_idx, main_idx, origin}
  localparam int ORIGIN_BIT   = 0;
  localparam int MAIN_IDX_LSB = 1;

  function automatic int regs_idx_lsb(input int mw);
    return MAIN_IDX_LSB + mw;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/data_selector_lane.sv
// Combinational single-lane mux: decodes one program entry against the
// snapshot buses and returns the selected slice, or zero when out of range.
module data_selector_lane
  import data_selector_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int MAIN_INPUTS = 16,
  parameter int REGS_INPUTS = 64,
  parameter int MW          = 4,
  parameter int RW          = 6,
  parameter int EW          = RW + MW + 1
) (
  input  logic [EW-1:0]                       entry_i,
  input  logic [MAIN_INPUTS*DATA_WIDTH-1:0]   main_i,
  input  logic [REGS_INPUTS*DATA_WIDTH-1:0]   regs_i,
  output logic [DATA_WIDTH-1:0]               slice_o
);

  localparam int REGS_LSB = regs_idx_lsb(MW);

  logic          origin_s;
  logic [MW-1:0] main_idx_s;
  logic [RW-1:0] regs_idx_s;

  assign origin_s   = entry_i[ORIGIN_BIT];
  assign main_idx_s = entry_i[MAIN_IDX_LSB +: MW];
  assign regs_idx_s = entry_i[REGS_LSB +: RW];

  // Range-checked slice select from the bus named by the origin bit
  always_comb begin
    slice_o = '0;
    if (origin_s) begin
      if (int'(regs_idx_s) < REGS_INPUTS) begin
        slice_o = regs_i[int'(regs_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        slice_o = '0;
      end
    end else begin
      if (int'(main_idx_s) < MAIN_INPUTS) begin
        slice_o = main_i[int'(main_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        slice_o = '0;
      end
    end
  end

endmodule

// File: rtl/data_selector_seq.sv
// Sequenced data selector: snapshots inputs on start, then streams the
// program beat by beat over valid/ready. Optional DATA_SELECTOR_SEQ_PARITY_EN.
module data_selector_seq
  import data_selector_pkg::*;
#(
  parameter int DATA_WIDTH       = 4,
  parameter int MAIN_INPUTS      = 16,
  parameter int REGS_INPUTS      = 64,
  parameter int SELECTOR_OUTPUTS = 4,
  parameter int PROG_DEPTH       = 16,
  localparam int MW    = $clog2(MAIN_INPUTS),
  localparam int RW    = $clog2(REGS_INPUTS),
  localparam int EW    = RW + MW + 1,
  localparam int BEATS = PROG_DEPTH / SELECTOR_OUTPUTS,
  localparam int BW    = width_of(BEATS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  loop,
  input  logic                                  wBusy,
  input  logic [MAIN_INPUTS*DATA_WIDTH-1:0]     wData,
  input  logic [REGS_INPUTS*DATA_WIDTH-1:0]     wRegs,
  input  logic [PROG_DEPTH*EW-1:0]              wSelec,
  output logic [SELECTOR_OUTPUTS*DATA_WIDTH-1:0] data_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BW-1:0]                         beat_idx,
  output logic                                  active,
  output logic                                  done
`ifdef DATA_SELECTOR_SEQ_PARITY_EN
  ,
  output logic [SELECTOR_OUTPUTS-1:0]           out_parity
`endif
);

  localparam int OW = SELECTOR_OUTPUTS * DATA_WIDTH;

  logic [MAIN_INPUTS*DATA_WIDTH-1:0] data_snap_q;
  logic [REGS_INPUTS*DATA_WIDTH-1:0] regs_snap_q;
  logic [PROG_DEPTH*EW-1:0]          prog_snap_q;
  logic                              loop_q;

  state_t          state_q, state_d;
  logic [BW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            active_q, active_d;
  logic            done_q, done_d;

  logic            capture_s;
  logic            load_s;
  logic            last_s;
  logic [OW-1:0]   lanes_s;

  assign capture_s = (state_q == ST_IDLE) && start;
  assign load_s    = (state_q == ST_RUN) && !wBusy && (!valid_q || out_ready);
  assign last_s    = (ptr_q == BW'(BEATS - 1));

  for (genvar k = 0; k < SELECTOR_OUTPUTS; k++) begin : g_lane
    logic [EW-1:0] entry_s;
    assign entry_s = prog_snap_q[(int'(ptr_q)*SELECTOR_OUTPUTS + k)*EW +: EW];

    data_selector_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MAIN_INPUTS (MAIN_INPUTS),
      .REGS_INPUTS (REGS_INPUTS),
      .MW          (MW),
      .RW          (RW),
      .EW          (EW)
    ) u_lane (
      .entry_i (entry_s),
      .main_i  (data_snap_q),
      .regs_i  (regs_snap_q),
      .slice_o (lanes_s[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Snapshot registers: the run only ever sees what was present at start
  always_ff @(posedge clk) begin
    if (rst) begin
      data_snap_q <= '0;
      regs_snap_q <= '0;
      prog_snap_q <= '0;
      loop_q      <= 1'b0;
    end else if (capture_s) begin
      data_snap_q <= wData;
      regs_snap_q <= wRegs;
      prog_snap_q <= wSelec;
      loop_q      <= loop;
    end
  end

  // Sequencer next-state and output-beat logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (load_s) begin
          data_d  = lanes_s;
          beat_d  = ptr_q;
          valid_d = 1'b1;
          if (last_s) begin
            ptr_d   = '0;
            state_d = loop_q ? ST_RUN : ST_DRAIN;
          end else begin
            ptr_d = ptr_q + BW'(1);
          end
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      ST_DRAIN: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    active_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      beat_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      beat_q   <= beat_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign beat_idx  = beat_q;
  assign active    = active_q;
  assign done      = done_q;

`ifdef DATA_SELECTOR_SEQ_PARITY_EN
  logic [SELECTOR_OUTPUTS-1:0] parity_q, parity_d;

  // Even parity per lane, computed from the beat about to be loaded
  always_comb begin
    parity_d = '0;
    for (int k = 0; k < SELECTOR_OUTPUTS; k++) begin
      parity_d[k] = even_parity(64'(lanes_s[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Parity travels with data_out
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= '0;
    end else if (load_s) begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_data_selector_seq.sv
// Directed self-checking bench for data_selector_seq at default parameters.
module tb_data_selector_seq;

  localparam int DW = 4;
  localparam int MI = 16;
  localparam int RI = 64;
  localparam int SO = 4;
  localparam int PD = 16;
  localparam int EW = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              loop;
  logic              wBusy;
  logic              out_ready;
  logic [MI*DW-1:0]  wData;
  logic [RI*DW-1:0]  wRegs;
  logic [PD*EW-1:0]  wSelec;
  logic [SO*DW-1:0]  data_out;
  logic              out_valid;
  logic [1:0]        beat_idx;
  logic              active;
  logic              done;
`ifdef DATA_SELECTOR_SEQ_PARITY_EN
  logic [SO-1:0]     out_parity;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_beat [4] = '{16'hcdef, 16'h89ab, 16'h4567, 16'h0123};
  localparam logic [63:0] DATA_PAT = 64'h0123456789abcdef;

  data_selector_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .loop      (loop),
    .wBusy     (wBusy),
    .wData     (wData),
    .wRegs     (wRegs),
    .wSelec    (wSelec),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_idx  (beat_idx),
    .active    (active),
    .done      (done)
`ifdef DATA_SELECTOR_SEQ_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [PD*EW-1:0] prog_main();
    logic [PD*EW-1:0] p;
    p = '0;
    for (int j = 0; j < PD; j++) p[j*EW +: EW] = {6'd0, 4'(j), 1'b0};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; loop = 1'b0; wBusy = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic launch(input logic lp);
    loop = lp; start = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick(); tick();
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=%h", data_out, 16'h0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL reset_beat got=%0d exp=0", beat_idx); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_single_pass();
    do_reset();
    wData = DATA_PAT; wRegs = '0; wSelec = prog_main();
    launch(1'b0);
    checks++; if (active !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL sp_start active=%b valid=%b exp 1/0", active, out_valid); end
    for (int b = 0; b < 4; b++) begin
      tick();
      checks++; if (data_out !== exp_beat[b]) begin errors++; $display("FAIL sp_data%0d got=%h exp=%h", b, data_out, exp_beat[b]); end
      checks++; if (beat_idx !== 2'(b) || out_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sp_ctl%0d idx=%0d valid=%b done=%b", b, beat_idx, out_valid, done); end
`ifdef DATA_SELECTOR_SEQ_PARITY_EN
      if (b == 0) begin
        checks++; if (out_parity !== 4'b0110) begin errors++; $display("FAIL sp_parity got=%b exp=0110", out_parity); end
      end
`endif
    end
    tick();
    checks++; if (done !== 1'b1 || active !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL sp_done done=%b active=%b valid=%b exp 1/0/0", done, active, out_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sp_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_regs();
    logic [PD*EW-1:0] p;
    do_reset();
    wData = DATA_PAT; wRegs = {32'h6789abcd, 224'd0};
    p = prog_main();
    p[0*EW +: EW] = {6'd63, 4'd0, 1'b1};
    p[1*EW +: EW] = {6'd56, 4'd0, 1'b1};
    p[2*EW +: EW] = {6'd0,  4'd5, 1'b0};
    p[3*EW +: EW] = {6'd60, 4'd0, 1'b1};
    wSelec = p;
    launch(1'b0);
    tick();
    checks++; if (data_out !== 16'h9ad6) begin errors++; $display("FAIL regs_beat0 got=%h exp=%h", data_out, 16'h9ad6); end
    tick(); tick(); tick();
    checks++; if (data_out !== 16'h0123) begin errors++; $display("FAIL regs_beat3 got=%h exp=%h", data_out, 16'h0123); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL regs_done got=%b exp=1", done); end
  endtask

  task automatic test_backpressure();
    do_reset();
    wData = DATA_PAT; wRegs = '0; wSelec = prog_main();
    launch(1'b0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (data_out !== 16'hcdef || beat_idx !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d data=%h idx=%0d valid=%b exp cdef/0/1", i, data_out, beat_idx, out_valid); end
    end
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      tick();
      checks++; if (data_out !== exp_beat[b] || beat_idx !== 2'(b)) begin errors++; $display("FAIL bp_beat%0d data=%h idx=%0d exp=%h", b, data_out, beat_idx, exp_beat[b]); end
    end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
  endtask

  task automatic test_busy();
    int n;
    int ndone;
    do_reset();
    wData = DATA_PAT; wRegs = '0; wSelec = prog_main();
    launch(1'b0);
    n = 0; ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c >= 2 && c <= 4) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL busy_noload c=%0d valid=%b exp=0", c, out_valid); end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (n > 3) begin
          errors++; $display("FAIL busy_extra beat=%0d data=%h exp none", n, data_out);
        end else if (data_out !== exp_beat[n] || beat_idx !== 2'(n)) begin
          errors++; $display("FAIL busy_beat%0d data=%h idx=%0d exp=%h", n, data_out, beat_idx, exp_beat[n]);
        end
        n++;
      end
      if (done === 1'b1) ndone++;
      wBusy = (c >= 1 && c <= 3);
    end
    checks++; if (n != 4) begin errors++; $display("FAIL busy_count got=%0d exp=4", n); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_loop_reset();
    do_reset();
    wData = DATA_PAT; wRegs = '0; wSelec = prog_main();
    launch(1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (data_out !== exp_beat[i % 4] || done !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL loop_beat%0d data=%h done=%b active=%b exp=%h", i, data_out, done, active, exp_beat[i % 4]); end
    end
    rst = 1'b1;
    tick();
    checks++; if (data_out !== 16'h0 || out_valid !== 1'b0 || beat_idx !== 2'd0) begin errors++; $display("FAIL loop_rst_out data=%h valid=%b idx=%0d exp 0", data_out, out_valid, beat_idx); end
    checks++; if (active !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL loop_rst_state active=%b done=%b exp 0/0", active, done); end
    rst = 1'b0;
    tick();
    checks++; if (active !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL loop_rst_idle active=%b valid=%b exp 0/0", active, out_valid); end
  endtask

  task automatic test_snapshot();
    do_reset();
    wData = DATA_PAT; wRegs = '0; wSelec = prog_main();
    launch(1'b0);
    wData = '0; wSelec = '0;
    start = 1'b1; loop = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
    checks++; if (data_out !== 16'hcdef) begin errors++; $display("FAIL snap_beat0 got=%h exp=cdef", data_out); end
    for (int b = 1; b < 4; b++) begin
      tick();
      checks++; if (data_out !== exp_beat[b]) begin errors++; $display("FAIL snap_beat%0d got=%h exp=%h", b, data_out, exp_beat[b]); end
    end
    tick();
    checks++; if (done !== 1'b1 || active !== 1'b0) begin errors++; $display("FAIL snap_done done=%b active=%b exp 1/0", done, active); end
    tick();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL snap_idle active=%b exp=0", active); end
    wData = DATA_PAT; wSelec = prog_main();
  endtask

  task automatic test_back_to_back();
    do_reset();
    wData = DATA_PAT; wRegs = '0; wSelec = prog_main();
    launch(1'b0);
    tick(); tick(); tick(); tick();
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (active !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_restart active=%b valid=%b exp 1/0", active, out_valid); end
    tick();
    checks++; if (data_out !== 16'hcdef || beat_idx !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_beat0 data=%h idx=%0d valid=%b exp cdef/0/1", data_out, beat_idx, out_valid); end
    tick(); tick(); tick();
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got=%b exp=1", done); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; loop = 1'b0; wBusy = 1'b0; out_ready = 1'b1;
    wData = '0; wRegs = '0; wSelec = '0;
    test_reset();
    test_single_pass();
    test_regs();
    test_backpressure();
    test_busy();
    test_loop_reset();
    test_snapshot();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
